snapshot_byte_reader: RTL and testbench

Multi-channel successor to the single-word byte mux on the EPM570 readout path. On a host latch strobe it captures a coherent snapshot of `CHANNELS` rotary-decoder counters, each `BITS` wide, then streams them to the host MCU one byte at a time over the 8-bit bus. Each snapshot is a frame with a sequence byte, and the host advances through it with a read strobe. All host strobes are asynchronous and are synchronised inside the block; everything else runs on the single system clock.

---
 rtl/lrd_readout_pkg.sv | 15 +
 rtl/strobe_sync.sv | 27 ++
 rtl/snapshot_byte_reader.sv | 128 ++++++++++++
 tb/tb_snapshot_byte_reader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lrd_readout_pkg.sv
// Shared constants and frame-geometry helpers for the LRD readout path.
package lrd_readout_pkg;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;
  localparam int         SEQ_W     = 8;

  function automatic int bytes_per_ch(input int bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int frame_len(input int ch, input int bits, input bit cks);
    return 1 + ch * bytes_per_ch(bits) + (cks ? 1 : 0);
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchroniser for an asynchronous host strobe, with one edge-history
// flop producing single-cycle rising and falling edge pulses.
module strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b00;
      hist <= 1'b0;
    end else begin
      sync <= {sync[0], strobe};
      hist <= sync[1];
    end
  end

  assign rise = sync[1] & ~hist;
  assign fall = ~sync[1] & hist;

endmodule

// File: rtl/snapshot_byte_reader.sv
// Captures a coherent multi-channel counter snapshot and streams it as a byte frame.
// Optional trailing XOR checksum byte: define SNAPSHOT_BYTE_READER_CHECKSUM_EN.
module snapshot_byte_reader
  import lrd_readout_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int CHANNELS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       latch,
  input  logic                       rd,
  input  logic [CHANNELS*BITS-1:0]   src,
  output logic [7:0]                 dst,
  output logic                       rdy,
  output logic                       eof
);

  localparam int BPC = bytes_per_ch(BITS);
  localparam int NB  = CHANNELS * BPC;
`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif
  localparam int                 L       = frame_len(CHANNELS, BITS, CKS);
  localparam int                 PTR_W   = $clog2(L + 1);
  localparam logic [PTR_W-1:0]   PTR_END = PTR_W'(L);

  logic             cap;
  logic             adv;
  logic             unused_latch_fall;
  logic             unused_rd_rise;

  logic [NB*8-1:0]  src_pad;
  logic [NB*8-1:0]  snapshot;
  logic [SEQ_W-1:0] seq;
  logic [SEQ_W-1:0] seq_next;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       frame_byte;

  strobe_sync u_latch_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (latch),
    .rise   (cap),
    .fall   (unused_latch_fall)
  );

  strobe_sync u_rd_sync (
    .clk    (clk),
    .rst    (rst),
    .strobe (rd),
    .rise   (unused_rd_rise),
    .fall   (adv)
  );

  // Each channel is zero-extended to a whole number of bytes.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_pad
      assign src_pad[gi*BPC*8 +: BPC*8] = (BPC*8)'(src[gi*BITS +: BITS]);
    end
  endgenerate

  assign seq_next = seq + SEQ_W'(1);

`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
  logic [7:0] cks;
  logic [7:0] cks_next;

  always_comb begin
    cks_next = seq_next;
    for (int i = 0; i < NB; i++) begin
      cks_next = cks_next ^ src_pad[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cks <= 8'h00;
    end else if (cap) begin
      cks <= cks_next;
    end
  end
`endif

  always_comb begin
    frame_byte = IDLE_BYTE;
    if (ptr == '0) begin
      frame_byte = seq;
    end
    for (int i = 0; i < NB; i++) begin
      if (ptr == PTR_W'(i + 1)) begin
        frame_byte = snapshot[i*8 +: 8];
      end
    end
`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
    if (ptr == PTR_W'(NB + 1)) begin
      frame_byte = cks;
    end
`endif
  end

  // A capture in the same cycle as a read edge takes priority and drops the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
      seq      <= '0;
      ptr      <= '0;
      rdy      <= 1'b0;
      dst      <= 8'h00;
      eof      <= 1'b0;
    end else begin
      if (cap) begin
        snapshot <= src_pad;
        seq      <= seq_next;
        ptr      <= '0;
        rdy      <= 1'b1;
      end else if (adv && (ptr != PTR_END)) begin
        ptr <= ptr + PTR_W'(1);
      end
      dst <= frame_byte;
      eof <= (ptr == PTR_END);
    end
  end

endmodule

// File: tb/tb_snapshot_byte_reader.sv
// Scoreboard bench: a 2x32 reader (a) and a 1x12 reader (b) on a shared clock and reset.
module tb_snapshot_byte_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        latch_a = 1'b0, rd_a = 1'b0;
  logic        latch_b = 1'b0, rd_b = 1'b0;
  logic [63:0] src_a = 64'h0;
  logic [11:0] src_b = 12'h0;
  logic [7:0]  dst_a, dst_b;
  logic        rdy_a, rdy_b, eof_a, eof_b;

  always #5 clk = ~clk;

  snapshot_byte_reader #(.BITS(32), .CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst), .latch(latch_a), .rd(rd_a), .src(src_a),
    .dst(dst_a), .rdy(rdy_a), .eof(eof_a)
  );

  snapshot_byte_reader #(.BITS(12), .CHANNELS(1)) dut_b (
    .clk(clk), .rst(rst), .latch(latch_b), .rd(rd_b), .src(src_b),
    .dst(dst_b), .rdy(rdy_b), .eof(eof_b)
  );

  typedef struct {
    bit         inst;
    string      name;
    logic [7:0] dst;
    logic       eof;
    logic       rdy;
  } exp_t;

  typedef struct {
    logic [7:0] dst;
    logic       eof;
  } vec_t;

`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
  localparam int NV = 10;
`else
  localparam int NV = 9;
`endif

  exp_t q[$];
  vec_t tbl[NV];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input bit inst, input string name, input logic [7:0] d,
                            input logic e, input logic r);
    exp_t x;
    x.inst = inst; x.name = name; x.dst = d; x.eof = e; x.rdy = r;
    q.push_back(x);
  endtask

  task automatic cmp(input string name, input string what, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s actual=%h required=%h", name, what, act, req);
    end
  endtask

  task automatic check_out();
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    checks--;
    x = q.pop_front();
    if (x.inst) begin
      cmp(x.name, "dst", dst_b, x.dst);
      cmp(x.name, "eof", {7'h0, eof_b}, {7'h0, x.eof});
      cmp(x.name, "rdy", {7'h0, rdy_b}, {7'h0, x.rdy});
      $display("b %-12s dst=%h eof=%b rdy=%b", x.name, dst_b, eof_b, rdy_b);
    end else begin
      cmp(x.name, "dst", dst_a, x.dst);
      cmp(x.name, "eof", {7'h0, eof_a}, {7'h0, x.eof});
      cmp(x.name, "rdy", {7'h0, rdy_a}, {7'h0, x.rdy});
      $display("a %-12s dst=%h eof=%b rdy=%b", x.name, dst_a, eof_a, rdy_a);
    end
  endtask

  task automatic pulse_latch(input bit inst);
    if (inst) latch_b = 1'b1; else latch_a = 1'b1;
    step(4);
    if (inst) latch_b = 1'b0; else latch_a = 1'b0;
    step(4);
  endtask

  task automatic pulse_rd(input bit inst);
    if (inst) rd_b = 1'b1; else rd_a = 1'b1;
    step(4);
    if (inst) rd_b = 1'b0; else rd_a = 1'b0;
    step(4);
  endtask

  initial begin
    tbl[0] = '{8'h78, 1'b0}; tbl[1] = '{8'h56, 1'b0};
    tbl[2] = '{8'h34, 1'b0}; tbl[3] = '{8'h12, 1'b0};
    tbl[4] = '{8'hBE, 1'b0}; tbl[5] = '{8'hBA, 1'b0};
    tbl[6] = '{8'hFE, 1'b0}; tbl[7] = '{8'hCA, 1'b0};
`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
    tbl[8] = '{8'h39, 1'b0}; tbl[9] = '{8'hFF, 1'b1};
`else
    tbl[8] = '{8'hFF, 1'b1};
`endif

    // Reset then idle.
    step(3);
    rst = 1'b0;
    expect_out(0, "idle", 8'h00, 1'b0, 1'b0);
    expect_out(1, "idle", 8'h00, 1'b0, 1'b0);
    step(10);
    check_out();
    check_out();

    // Reads before any capture walk through a zero snapshot.
    for (int i = 0; i < 3; i++) begin
      expect_out(0, "rd_nolatch", 8'h00, 1'b0, 1'b0);
      pulse_rd(0);
      check_out();
    end

    // Full frame readout; src changes mid-frame must not show.
    src_a = {32'hCAFEBABE, 32'h12345678};
    expect_out(0, "seq1", 8'h01, 1'b0, 1'b1);
    pulse_latch(0);
    check_out();
    for (int i = 0; i < NV; i++) begin
      if (i == 4) src_a = {$urandom, $urandom};
      expect_out(0, $sformatf("frame%0d", i + 1), tbl[i].dst, tbl[i].eof, 1'b1);
      pulse_rd(0);
      check_out();
    end
    expect_out(0, "saturate_a", 8'hFF, 1'b1, 1'b1);
    pulse_rd(0);
    check_out();

    // Second capture restarts at byte 0.
    src_a = {32'h55667788, 32'h11223344};
    expect_out(0, "seq2", 8'h02, 1'b0, 1'b1);
    pulse_latch(0);
    check_out();
    expect_out(0, "seq2_b1", 8'h44, 1'b0, 1'b1);
    pulse_rd(0);
    check_out();

    // Capture and read edges in the same cycle: read is dropped.
    rd_a = 1'b1;
    step(4);
    expect_out(0, "simul_seq3", 8'h03, 1'b0, 1'b1);
    latch_a = 1'b1;
    rd_a = 1'b0;
    step(4);
    latch_a = 1'b0;
    step(4);
    check_out();
    expect_out(0, "simul_b1", 8'h44, 1'b0, 1'b1);
    pulse_rd(0);
    check_out();

    // 12-bit single channel with pad bits and saturation.
    src_b = 12'hABC;
    expect_out(1, "b_seq1", 8'h01, 1'b0, 1'b1);
    pulse_latch(1);
    check_out();
    expect_out(1, "b_lo", 8'hBC, 1'b0, 1'b1);
    pulse_rd(1);
    check_out();
    expect_out(1, "b_hi", 8'h0A, 1'b0, 1'b1);
    pulse_rd(1);
    check_out();
`ifdef SNAPSHOT_BYTE_READER_CHECKSUM_EN
    expect_out(1, "b_cks", 8'hB7, 1'b0, 1'b1);
    pulse_rd(1);
    check_out();
`endif
    for (int i = 0; i < 3; i++) begin
      expect_out(1, "b_end", 8'hFF, 1'b1, 1'b1);
      pulse_rd(1);
      check_out();
    end

    // Reset mid-readout with latch held high.
    pulse_rd(0);
    latch_a = 1'b1;
    rst = 1'b1;
    expect_out(0, "in_reset", 8'h00, 1'b0, 1'b0);
    expect_out(1, "in_reset", 8'h00, 1'b0, 1'b0);
    step(3);
    check_out();
    check_out();
    rst = 1'b0;
    expect_out(0, "rel_e1", 8'h00, 1'b0, 1'b0);
    step(1);
    check_out();
    expect_out(0, "rel_e2", 8'h00, 1'b0, 1'b0);
    step(1);
    check_out();
    expect_out(0, "rel_e3", 8'h00, 1'b0, 1'b1);
    step(1);
    check_out();
    expect_out(0, "rel_e4", 8'h01, 1'b0, 1'b1);
    step(1);
    check_out();
    expect_out(0, "rel_hold", 8'h01, 1'b0, 1'b1);
    step(12);
    check_out();
    latch_a = 1'b0;
    step(4);

    // Sequence wrap after 256 captures since reset.
    for (int i = 0; i < 253; i++) pulse_latch(0);
    expect_out(0, "seq_ff", 8'hFF, 1'b0, 1'b1);
    pulse_latch(0);
    check_out();
    expect_out(0, "seq_wrap", 8'h00, 1'b0, 1'b1);
    pulse_latch(0);
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
